sw_debounce: RTL and testbench

- Input conditioner between the board switch pins and the CPU input port 1, the port that carries the switch word.
- Per-bit synchronisation, counter-based debounce, single-cycle edge pulses and sticky event flags.
- The CPU samples on a slower divided clock and can miss single-cycle pulses, so software polls `event_flags` and clears them with `ack`.

---
 rtl/io_pkg.sv | 10 +
 rtl/debounce_bit.sv | 51 +++++
 rtl/sw_debounce.sv | 55 +++++
 tb/tb_sw_debounce.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared constants and types for the CPU input-port conditioning logic.
package io_pkg;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 500000;  // 5 ms at 100 MHz

    // Width of the switch word seen on CPU input port 1.
    typedef logic [15:0] sw_word_t;

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: synchroniser chain, agreement counter, stable level and
// single-cycle rise/fall pulses that coincide with the level update.
module debounce_bit
    import io_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic [CW-1:0]          cnt;

    assign sync = sync_q[SYNC_STAGES-1];

    // The count clears on acceptance, so it never needs to saturate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt    <= '0;
            level  <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sw};
            rise   <= 1'b0;
            fall   <= 1'b0;
            if (sync == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level <= sync;
                cnt   <= '0;
                rise  <= sync;
                fall  <= ~sync;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/sw_debounce.sv
// Switch-word conditioner: per-bit debounce plus sticky change flags that
// software polls on its slower clock and clears with ack/ack_mask.
module sw_debounce
    import io_pkg::*;
#(
    parameter int WIDTH           = $bits(sw_word_t),
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] event_flags,
    output logic             event_any,
    input  logic             ack,
    input  logic [WIDTH-1:0] ack_mask
);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2) begin : g_param_check
        $error("sw_debounce: SYNC_STAGES and DEBOUNCE_CYCLES must both be >= 2");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk   (clk),
            .rst_n (rst_n),
            .sw    (sw_in[i]),
            .level (sw_out[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

    // ack is a plain level strobe with no handshake: every edge that sees
    // ack=1 clears the masked flags, and a same-edge rise/fall wins.
    logic [WIDTH-1:0] clear;
    assign clear = {WIDTH{ack}} & ack_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            event_flags <= '0;
        end else begin
            event_flags <= (event_flags & ~clear) | rise | fall;
        end
    end

    assign event_any = |event_flags;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with a pulse scoreboard keyed on cycle number.
module tb_sw_debounce;
    import io_pkg::*;

    localparam int W = 16;

    logic     clk   = 1'b0;
    logic     rst_n = 1'b1;
    sw_word_t sw_in;
    sw_word_t sw_out, rise, fall, event_flags, ack_mask;
    logic     event_any, ack;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // {cycle[15:0], sw_out, rise, fall}
    logic [63:0] exp_q[$];

    sw_debounce #(
        .WIDTH           (W),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sw_in       (sw_in),
        .sw_out      (sw_out),
        .rise        (rise),
        .fall        (fall),
        .event_flags (event_flags),
        .event_any   (event_any),
        .ack         (ack),
        .ack_mask    (ack_mask)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_pulse(input int at, input sw_word_t lvl, input sw_word_t r, input sw_word_t f);
        exp_q.push_back({16'(at), lvl, r, f});
    endtask

    task automatic do_ack(input sw_word_t mask, input int cycles);
        ack      = 1'b1;
        ack_mask = mask;
        tick(cycles);
        ack      = 1'b0;
        ack_mask = '0;
    endtask

    // monitor: every cycle with a pulse must match the head of the queue
    always @(negedge clk) begin
        if (rst_n && (rise | fall) != '0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_pulse: got rise=%h fall=%h sw_out=%h expected none (cycle %0d)",
                         rise, fall, sw_out, cyc);
            end else begin
                check("pulse", {16'(cyc), sw_out, rise, fall}, exp_q.pop_front());
            end
        end
    end

    task automatic report;
        $display("%0d/%0d checks passed", n_pass, n_checks);
    endtask

    initial begin
        #200000;
        n_checks++;
        $display("FAIL watchdog: got timeout expected completion");
        report();
        $finish;
    end

    initial begin
        int n0;
        sw_in    = '0;
        ack      = 1'b0;
        ack_mask = '0;

        // reset values, idle hold with all switches low
        #1 rst_n = 1'b0;
        #2 check("reset_outputs", {sw_out, rise, fall, event_flags, 15'd0, event_any}, 64'd0);
        tick(2);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("idle", {sw_out, rise, fall, event_flags, 15'd0, event_any}, 64'd0);
        end

        // clean step on bit 0: visible 5 edges after the first sampling edge
        n0 = cyc;
        sw_in[0] = 1'b1;
        expect_pulse(n0 + 6, 16'h0001, 16'h0001, 16'h0000);
        tick(6);
        check("flags_before_step", 64'(event_flags), 64'h0000);
        tick(1);
        check("flags_after_step", 64'(event_flags), 64'h0001);
        check("any_after_step", 64'(event_any), 64'd1);
        check("sw_out_after_step", 64'(sw_out), 64'h0001);

        // glitch on bit 3 lasting 3 cycles is rejected
        sw_in[3] = 1'b1;
        tick(3);
        sw_in[3] = 1'b0;
        tick(20);
        check("glitch_sw_out", 64'(sw_out), 64'h0001);
        check("glitch_flags", 64'(event_flags), 64'h0001);

        // bounce on bit 5, then settle high: exactly one rise
        for (int i = 0; i < 10; i++) begin
            sw_in[5] = ~sw_in[5];
            tick(1);
        end
        n0 = cyc;
        sw_in[5] = 1'b1;
        expect_pulse(n0 + 6, 16'h0021, 16'h0020, 16'h0000);
        tick(8);
        check("bounce_sw_out", 64'(sw_out), 64'h0021);
        check("bounce_flags", 64'(event_flags), 64'h0021);

        // ack=0 ignores the mask
        ack_mask = 16'hFFFF;
        tick(2);
        ack_mask = '0;
        check("mask_without_ack", 64'(event_flags), 64'h0021);

        // partial clear, then held ack repeats harmlessly
        do_ack(16'h0001, 1);
        check("ack_bit0", 64'(event_flags), 64'h0020);
        do_ack(16'h0001, 3);
        check("ack_held", 64'(event_flags), 64'h0020);
        do_ack(16'h0020, 1);
        check("ack_bit5", 64'(event_flags), 64'h0000);
        check("any_cleared", 64'(event_any), 64'd0);

        // falling bit 5 with a coincident ack: the set wins
        n0 = cyc;
        sw_in[5] = 1'b0;
        expect_pulse(n0 + 6, 16'h0001, 16'h0000, 16'h0020);
        tick(6);
        do_ack(16'h0020, 1);
        check("set_wins_flags", 64'(event_flags), 64'h0020);
        check("set_wins_any", 64'(event_any), 64'd1);

        // reset partway through a count on bit 7, no clock edge needed
        sw_in[7] = 1'b1;
        tick(3);
        #2 rst_n = 1'b0;
        #1 check("async_reset", {sw_out, rise, fall, event_flags, 15'd0, event_any}, 64'd0);
        tick(2);
        check("reset_hold", {sw_out, event_flags}, 64'd0);

        // release with every switch already high: power-up events
        n0 = cyc;
        sw_in = 16'hFFFF;
        rst_n = 1'b1;
        expect_pulse(n0 + 6, 16'hFFFF, 16'hFFFF, 16'h0000);
        tick(6);
        check("powerup_flags_pending", 64'(event_flags), 64'h0000);
        tick(1);
        check("powerup_flags", 64'(event_flags), 64'hFFFF);
        check("powerup_sw_out", 64'(sw_out), 64'hFFFF);
        check("powerup_rise_gone", 64'(rise), 64'h0000);
        check("powerup_any", 64'(event_any), 64'd1);

        tick(3);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        report();
        $finish;
    end

endmodule
